// File: rtl/mem_bank_2rw_arbiter.sv
// Round-robin arbiter sharing a 2-port (RW0/RW1) masked memory bank among NUM_REQ requesters.
// Optional build macro MEM_ARB_STATS_EN adds hazard/dual-grant counters (stat_conflicts, stat_busy, stat_clr).
module mem_bank_2rw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_wmode,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_rdata,
  output logic                        RW0_en,
  output logic                        RW0_wmode,
  output logic [ADDR_W-1:0]           RW0_addr,
  output logic [DATA_W-1:0]           RW0_wdata,
  output logic [DATA_W-1:0]           RW0_wmask,
  input  logic [DATA_W-1:0]           RW0_rdata,
  output logic                        RW1_en,
  output logic                        RW1_wmode,
  output logic [ADDR_W-1:0]           RW1_addr,
  output logic [DATA_W-1:0]           RW1_wdata,
  output logic [DATA_W-1:0]           RW1_wmask,
  input  logic [DATA_W-1:0]           RW1_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [15:0]                 stat_conflicts,
  output logic [15:0]                 stat_busy
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_badNumReq
      $error("mem_bank_2rw_arbiter: NUM_REQ must be in 2..8");
    end
  endgenerate

  function automatic logic [PTR_W-1:0] f_wrap(input int v);
    return PTR_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
  endfunction

  logic [PTR_W-1:0]   r_rrPtr;
  logic [NUM_REQ-1:0] r_rspValid;
  logic [NUM_REQ*DATA_W-1:0] r_rspRdata;

  logic               w_haveA;
  logic               w_haveB;
  logic               w_hazard;
  logic [PTR_W-1:0]   w_idxA;
  logic [PTR_W-1:0]   w_idxB;
  logic [PTR_W-1:0]   w_idxC;
  logic [PTR_W-1:0]   w_rrNext;
  logic [ADDR_W-1:0]  w_addrA;
  logic               w_wmodeA;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_rdSel0;
  logic [NUM_REQ-1:0] w_rdSel1;

  // Scan from r_rrPtr: first valid is A (RW0); later candidates that collide with A
  // on address with a write involved are skipped, the first clean one becomes B (RW1).
  always_comb begin
    w_haveA  = 1'b0;
    w_haveB  = 1'b0;
    w_hazard = 1'b0;
    w_idxA   = '0;
    w_idxB   = '0;
    w_idxC   = '0;
    w_addrA  = '0;
    w_wmodeA = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idxC = f_wrap(int'(r_rrPtr) + k);
      if (req_valid[w_idxC]) begin
        if (!w_haveA) begin
          w_haveA  = 1'b1;
          w_idxA   = w_idxC;
          w_addrA  = req_addr[w_idxC*ADDR_W +: ADDR_W];
          w_wmodeA = req_wmode[w_idxC];
        end else if (!w_haveB) begin
          if ((req_addr[w_idxC*ADDR_W +: ADDR_W] == w_addrA) && (req_wmode[w_idxC] || w_wmodeA)) begin
            w_hazard = 1'b1;
          end else begin
            w_haveB = 1'b1;
            w_idxB  = w_idxC;
          end
        end
      end
    end
  end

  always_comb begin
    w_grant  = '0;
    w_rdSel0 = '0;
    w_rdSel1 = '0;
    if (w_haveA) begin
      w_grant[w_idxA]  = 1'b1;
      w_rdSel0[w_idxA] = !req_wmode[w_idxA];
    end
    if (w_haveB) begin
      w_grant[w_idxB]  = 1'b1;
      w_rdSel1[w_idxB] = !req_wmode[w_idxB];
    end
    w_rrNext = f_wrap(int'(w_haveB ? w_idxB : w_idxA) + 1);
  end

  // Unused ports are fully zeroed so the bank sees no stray address/data activity.
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    RW0_wmask = '0;
    RW1_en    = 1'b0;
    RW1_wmode = 1'b0;
    RW1_addr  = '0;
    RW1_wdata = '0;
    RW1_wmask = '0;
    if (w_haveA) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_wmode[w_idxA];
      RW0_addr  = req_addr[w_idxA*ADDR_W +: ADDR_W];
      RW0_wdata = req_wdata[w_idxA*DATA_W +: DATA_W];
      RW0_wmask = req_wmask[w_idxA*DATA_W +: DATA_W];
    end
    if (w_haveB) begin
      RW1_en    = 1'b1;
      RW1_wmode = req_wmode[w_idxB];
      RW1_addr  = req_addr[w_idxB*ADDR_W +: ADDR_W];
      RW1_wdata = req_wdata[w_idxB*DATA_W +: DATA_W];
      RW1_wmask = req_wmask[w_idxB*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr    <= '0;
      r_rspValid <= '0;
      r_rspRdata <= '0;
    end else begin
      if (w_haveA) begin
        r_rrPtr <= w_rrNext;
      end
      r_rspValid <= w_rdSel0 | w_rdSel1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_rdSel0[i]) begin
          r_rspRdata[i*DATA_W +: DATA_W] <= RW0_rdata;
        end else if (w_rdSel1[i]) begin
          r_rspRdata[i*DATA_W +: DATA_W] <= RW1_rdata;
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_statConflicts;
  logic [15:0] r_statBusy;

  // Saturating counters; a synchronous clear takes priority over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statConflicts <= '0;
      r_statBusy      <= '0;
    end else if (stat_clr) begin
      r_statConflicts <= '0;
      r_statBusy      <= '0;
    end else begin
      if (w_hazard && (r_statConflicts != 16'hFFFF)) begin
        r_statConflicts <= r_statConflicts + 16'd1;
      end
      if (w_haveB && (r_statBusy != 16'hFFFF)) begin
        r_statBusy <= r_statBusy + 16'd1;
      end
    end
  end

  assign stat_conflicts = r_statConflicts;
  assign stat_busy      = r_statBusy;
`endif

endmodule
